// File: rtl/byte_serializer.sv
// byte_serializer: unpacks NBYTES-wide words into an MSB-first byte stream with valid/ready on both sides.
// Define BYTE_SERIALIZER_SKID_EN to add a one-word holding register for 1 byte/cycle throughput.
module byte_serializer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*NBYTES-1:0]   data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
);
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [8*NBYTES-1:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d, done_q, done_d;
  logic accept, xfer, last;
  assign accept = in_valid && in_ready;
  assign xfer = out_valid_q && out_ready;
  assign last = cnt_q == LAST;
  assign data_out = sreg_q[8*NBYTES-1 -: 8];
  assign out_valid = out_valid_q;
  assign done = done_q;
  assign out_valid_d = state_d == SEND;
  assign done_d = state_d == SEND && cnt_d == LAST;
`ifdef BYTE_SERIALIZER_SKID_EN
  logic [8*NBYTES-1:0] hold_q, hold_d;
  logic hold_full_q, hold_full_d;
  assign in_ready = reset && (state_q == IDLE || !hold_full_q);
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    if (state_q == IDLE) begin
      if (accept) begin
        sreg_d = data_in;
        cnt_d = '0;
        state_d = SEND;
      end
    end else begin
      if (accept) begin
        hold_d = data_in;
        hold_full_d = 1'b1;
      end
      if (xfer && !last) begin
        sreg_d = sreg_q << 8;
        cnt_d = cnt_q + 1'b1;
      end else if (xfer) begin
        // a word arriving on the final-byte edge skips the holding register
        cnt_d = '0;
        hold_full_d = 1'b0;
        sreg_d = hold_full_q ? hold_q : data_in;
        state_d = (hold_full_q || accept) ? SEND : IDLE;
      end
    end
  end
`else
  assign in_ready = reset && state_q == IDLE;
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (accept) begin
        sreg_d = data_in;
        cnt_d = '0;
        state_d = SEND;
      end
    end else if (xfer && !last) begin
      sreg_d = sreg_q << 8;
      cnt_d = cnt_q + 1'b1;
    end else if (xfer) begin
      state_d = IDLE;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
`ifdef BYTE_SERIALIZER_SKID_EN
      hold_q <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      done_q <= done_d;
`ifdef BYTE_SERIALIZER_SKID_EN
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed vector table plus hand sequences for byte_serializer.
module tb_byte_serializer;
`ifdef BYTE_SERIALIZER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, in_valid, out_ready, in_ready, out_valid, done;
  logic [31:0] data_in;
  logic [7:0] data_out;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  byte_serializer #(.NBYTES(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );
  typedef struct {
    logic r, iv;
    logic [31:0] d;
    logic ordy, rdy_ns, rdy_sk, ov;
    logic [7:0] dout;
    logic dn, cd;
  } vec_t;
  typedef logic [9:0] seq_t[11];
  vec_t tbl[18];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic cyc(input logic r, input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    reset = r;
    in_valid = iv;
    data_in = d;
    out_ready = ordy;
    #1;
  endtask
  // source holds w1 until accepted, then w2 until accepted; e is {out_valid, done, byte} per cycle
  task automatic run_pair(input string n, input logic [31:0] w1, input logic [31:0] w2, input seq_t e);
    int acc = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, acc < 2, acc == 0 ? w1 : w2, 1'b1);
      chk($sformatf("%s c%0d", n, i), {22'd0, out_valid, done, out_valid ? data_out : 8'h00}, {22'd0, e[i]});
      if (in_valid && in_ready) acc++;
    end
  endtask
  initial begin
    logic [7:0] mb[4];
    tbl[0]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hDE, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBE, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hDE, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBE, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    reset = 1'b0;
    in_valid = 1'b1;
    data_in = 32'hDEADBEEF;
    out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, SKID ? tbl[i].rdy_sk : tbl[i].rdy_ns});
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("v%0d done", i), {31'd0, done}, {31'd0, tbl[i].dn});
      if (tbl[i].cd) chk($sformatf("v%0d data_out", i), {24'd0, data_out}, {24'd0, tbl[i].dout});
    end
    if (SKID)
      run_pair("b2b", 32'h01020304, 32'hA0B0C0D0,
        '{10'h000, 10'h201, 10'h202, 10'h203, 10'h304, 10'h2A0, 10'h2B0, 10'h2C0, 10'h3D0, 10'h000, 10'h000});
    else
      run_pair("b2b", 32'h01020304, 32'hA0B0C0D0,
        '{10'h000, 10'h201, 10'h202, 10'h203, 10'h304, 10'h000, 10'h2A0, 10'h2B0, 10'h2C0, 10'h3D0, 10'h000});
    if (SKID)
      run_pair("ign", 32'hCAFEF00D, 32'h0,
        '{10'h000, 10'h2CA, 10'h2FE, 10'h2F0, 10'h30D, 10'h200, 10'h200, 10'h200, 10'h300, 10'h000, 10'h000});
    else
      run_pair("ign", 32'hCAFEF00D, 32'h0,
        '{10'h000, 10'h2CA, 10'h2FE, 10'h2F0, 10'h30D, 10'h000, 10'h200, 10'h200, 10'h200, 10'h300, 10'h000});
    cyc(1'b1, 1'b1, 32'h11223344, 1'b1);
    chk("mid accept rdy", {31'd0, in_ready}, 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mid byte0", {23'd0, out_valid, data_out}, {23'd1, 8'h11});
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mid byte1", {23'd0, out_valid, data_out}, {23'd1, 8'h22});
    cyc(1'b0, 1'b1, 32'h55667788, 1'b1);
    chk("mid rst rdy", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mid post rst", {21'd0, in_ready, out_valid, done, data_out}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    cyc(1'b1, 1'b1, 32'h55667788, 1'b1);
    chk("mid new accept", {31'd0, in_ready}, 32'd1);
    mb = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      chk($sformatf("mid new byte%0d", i), {22'd0, out_valid, done, data_out}, {22'd0, 1'b1, i == 3, mb[i]});
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mid idle", {30'd0, out_valid, done}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
